// File: rtl/sync_fifo_pkg.sv
// Shared constants and the pointer-wrap helper for the flexible synchronous FIFO.
package sync_fifo_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 8;

   // Explicit wrap so DEPTH need not be a power of two.
   function automatic int ptr_next(input int ptr, input int depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// WIDTH x DEPTH storage: registered write port, asynchronous read port, no reset.
module sync_fifo_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with arbitrary depth, standard or first-word-fall-through
// read mode, occupancy count, programmable level flags and sticky error flags.
module sync_fifo_flex
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int FWFT       = 0,
   parameter int AFULL_LVL  = DEPTH - 1,
   parameter int AEMPTY_LVL = 1,
   localparam int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             w_en,
   input  logic             r_en,
   input  logic             clr_err,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [CNT_W-1:0] count,
   output logic             overflow,
   output logic             underflow
);

   localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [WIDTH-1:0] rd_data;
   logic [WIDTH-1:0] dout_q;
   logic             wa;
   logic             ra;

   // No pass-through at full and no bypass at empty: accept purely on state.
   assign wa = w_en & ~full;
   assign ra = r_en & ~empty;

   assign full         = (count == CNT_W'(DEPTH));
   assign empty        = (count == '0);
   assign almost_full  = (count >= CNT_W'(AFULL_LVL));
   assign almost_empty = (count <= CNT_W'(AEMPTY_LVL));

   sync_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (wa & ~rst),
      .waddr (wr_ptr),
      .wdata (data_in),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         dout_q    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wa) begin
            wr_ptr <= PTR_W'(ptr_next(32'(wr_ptr), DEPTH));
         end
         if (ra) begin
            rd_ptr <= PTR_W'(ptr_next(32'(rd_ptr), DEPTH));
            dout_q <= rd_data;
         end
         case ({wa, ra})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         // A new error event in the same cycle as clr_err keeps the flag set.
         if (w_en & full) begin
            overflow <= 1'b1;
         end else if (clr_err) begin
            overflow <= 1'b0;
         end
         if (r_en & empty) begin
            underflow <= 1'b1;
         end else if (clr_err) begin
            underflow <= 1'b0;
         end
      end
   end

   always_comb begin
      data_out = dout_q;
      if (FWFT != 0) begin
         data_out = empty ? '0 : rd_data;
      end
   end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Randomised and directed bench for sync_fifo_flex, DEPTH=6, both read modes.
module tb_sync_fifo_flex;

   localparam int W = 8;
   localparam int D = 6;
   localparam int CW = $clog2(D + 1);

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic w_en = 1'b0;
   logic r_en = 1'b0;
   logic clr_err = 1'b0;
   logic [W-1:0] data_in = '0;

   logic [W-1:0]  data_out0, data_out1;
   logic          full0, empty0, afull0, aempty0, ovf0, udf0;
   logic          full1, empty1, afull1, aempty1, ovf1, udf1;
   logic [CW-1:0] count0, count1;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a queue of stored words plus the registered output and error flags.
   logic [W-1:0] q[$];
   logic [W-1:0] m_dout = '0;
   logic         m_ovf  = 1'b0;
   logic         m_udf  = 1'b0;

   always #5 clk = ~clk;

   sync_fifo_flex #(.WIDTH(W), .DEPTH(D), .FWFT(0)) dut0 (
      .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .clr_err(clr_err),
      .data_in(data_in), .data_out(data_out0), .full(full0), .empty(empty0),
      .almost_full(afull0), .almost_empty(aempty0), .count(count0),
      .overflow(ovf0), .underflow(udf0)
   );

   sync_fifo_flex #(.WIDTH(W), .DEPTH(D), .FWFT(1)) dut1 (
      .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .clr_err(clr_err),
      .data_in(data_in), .data_out(data_out1), .full(full1), .empty(empty1),
      .almost_full(afull1), .almost_empty(aempty1), .count(count1),
      .overflow(ovf1), .underflow(udf1)
   );

   task automatic model_edge();
      bit m_full, m_empty;
      m_full  = (q.size() == D);
      m_empty = (q.size() == 0);
      if (w_en && m_full) m_ovf = 1'b1;
      else if (clr_err)   m_ovf = 1'b0;
      if (r_en && m_empty) m_udf = 1'b1;
      else if (clr_err)    m_udf = 1'b0;
      if (r_en && !m_empty) m_dout = q.pop_front();
      if (w_en && !m_full)  q.push_back(data_in);
   endtask

   task automatic tick(input logic w, input logic r, input logic c, input logic [W-1:0] d);
      w_en = w; r_en = r; clr_err = c; data_in = d;
      model_edge();
      @(posedge clk); #1;
      w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
   endtask

   task automatic do_rst(input logic w);
      rst = 1'b1; w_en = w; r_en = w; clr_err = 1'b0; data_in = 8'hEE;
      q.delete(); m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; w_en = 1'b0; r_en = 1'b0;
   endtask

   task automatic test_reset();
      do_rst(1'b0);
      do_rst(1'b0);
      n_tests++;
      if ({count0, full0, empty0, afull0, aempty0} !== {3'd0, 1'b0, 1'b1, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_flags got cnt=%0d f=%b e=%b af=%b ae=%b exp cnt=0 f=0 e=1 af=0 ae=1",
                  count0, full0, empty0, afull0, aempty0);
      end
      n_tests++;
      if ({data_out0, data_out1, ovf0, udf0} !== {8'h00, 8'h00, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_out got d0=%h d1=%h ovf=%b udf=%b exp 00 00 0 0",
                  data_out0, data_out1, ovf0, udf0);
      end
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < D; i++) begin
         tick(1'b1, 1'b0, 1'b0, 8'h11 + 8'(i));
         n_tests++;
         if ({count0, afull0, full0} !== {3'(i + 1), (i + 1 >= 5), (i + 1 == 6)}) begin
            n_fail++;
            $display("FAIL fill_level[%0d] got cnt=%0d af=%b f=%b exp cnt=%0d af=%b f=%b",
                     i, count0, afull0, full0, i + 1, (i + 1 >= 5), (i + 1 == 6));
         end
      end
      tick(1'b1, 1'b0, 1'b0, 8'h77);
      n_tests++;
      if ({ovf0, count0, full0} !== {1'b1, 3'd6, 1'b1}) begin
         n_fail++;
         $display("FAIL overflow_set got ovf=%b cnt=%0d f=%b exp 1 6 1", ovf0, count0, full0);
      end
      for (int i = 0; i < D; i++) begin
         tick(1'b0, 1'b1, 1'b0, 8'h00);
         n_tests++;
         if (data_out0 !== 8'h11 + 8'(i)) begin
            n_fail++;
            $display("FAIL drain_data[%0d] got %h exp %h", i, data_out0, 8'h11 + 8'(i));
         end
      end
      n_tests++;
      if ({empty0, count0} !== {1'b1, 3'd0}) begin
         n_fail++;
         $display("FAIL drain_empty got e=%b cnt=%0d exp 1 0", empty0, count0);
      end
      tick(1'b0, 1'b0, 1'b1, 8'h00);
      n_tests++;
      if (ovf0 !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow_clear got %b exp 0", ovf0);
      end
   endtask

   task automatic test_wrap();
      logic [W-1:0] d;
      for (int i = 0; i < 20; i++) begin
         d = 8'($urandom);
         tick(1'b1, 1'b0, 1'b0, d);
         n_tests++;
         if (count0 !== 3'd1) begin
            n_fail++;
            $display("FAIL wrap_cnt_push[%0d] got %0d exp 1", i, count0);
         end
         tick(1'b0, 1'b1, 1'b0, 8'h00);
         n_tests++;
         if ({data_out0, count0, ovf0, udf0} !== {d, 3'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_pop[%0d] got d=%h cnt=%0d ovf=%b udf=%b exp d=%h cnt=0 0 0",
                     i, data_out0, count0, ovf0, udf0, d);
         end
      end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 8'($urandom));
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, 1'b1, 1'b0, 8'($urandom));
         n_tests++;
         if ({count0, data_out0} !== {3'd3, m_dout}) begin
            n_fail++;
            $display("FAIL simul_rw[%0d] got cnt=%0d d=%h exp cnt=3 d=%h", i, count0, data_out0, m_dout);
         end
      end
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 8'($urandom));
      tick(1'b1, 1'b1, 1'b0, 8'hFF);
      n_tests++;
      if ({count0, ovf0, data_out0} !== {3'd5, 1'b1, m_dout}) begin
         n_fail++;
         $display("FAIL full_rw got cnt=%0d ovf=%b d=%h exp cnt=5 ovf=1 d=%h", count0, ovf0, data_out0, m_dout);
      end
      while (q.size() != 0) begin
         tick(1'b0, 1'b1, 1'b0, 8'h00);
         n_tests++;
         if (data_out0 !== m_dout) begin
            n_fail++;
            $display("FAIL simul_drain got %h exp %h", data_out0, m_dout);
         end
      end
      tick(1'b0, 1'b0, 1'b1, 8'h00);
   endtask

   task automatic test_underflow();
      tick(1'b1, 1'b1, 1'b0, 8'hA5);
      n_tests++;
      if ({udf0, count0} !== {1'b1, 3'd1}) begin
         n_fail++;
         $display("FAIL empty_rw got udf=%b cnt=%0d exp 1 1", udf0, count0);
      end
      tick(1'b0, 1'b1, 1'b0, 8'h00);
      n_tests++;
      if (data_out0 !== 8'hA5) begin
         n_fail++;
         $display("FAIL empty_rw_data got %h exp a5", data_out0);
      end
      tick(1'b0, 1'b0, 1'b1, 8'h00);
      n_tests++;
      if (udf0 !== 1'b0) begin
         n_fail++;
         $display("FAIL underflow_clear got %b exp 0", udf0);
      end
      tick(1'b0, 1'b1, 1'b1, 8'h00);
      n_tests++;
      if (udf0 !== 1'b1) begin
         n_fail++;
         $display("FAIL set_beats_clear got %b exp 1", udf0);
      end
      tick(1'b0, 1'b0, 1'b1, 8'h00);
   endtask

   task automatic test_fwft();
      tick(1'b1, 1'b0, 1'b0, 8'h3C);
      n_tests++;
      if ({data_out1, empty1} !== {8'h3C, 1'b0}) begin
         n_fail++;
         $display("FAIL fwft_show got d=%h e=%b exp 3c 0", data_out1, empty1);
      end
      tick(1'b0, 1'b1, 1'b0, 8'h00);
      n_tests++;
      if ({data_out1, empty1, data_out0} !== {8'h00, 1'b1, 8'h3C}) begin
         n_fail++;
         $display("FAIL fwft_pop got d1=%h e=%b d0=%h exp 00 1 3c", data_out1, empty1, data_out0);
      end
   endtask

   task automatic test_reset_mid();
      tick(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 8'($urandom));
      tick(1'b0, 1'b1, 1'b0, 8'h00);
      tick(1'b1, 1'b0, 1'b0, 8'h99);
      do_rst(1'b1);
      n_tests++;
      if ({count0, empty0, data_out0, ovf0, udf0, count1} !== {3'd0, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0}) begin
         n_fail++;
         $display("FAIL mid_reset got cnt=%0d e=%b d=%h ovf=%b udf=%b cnt1=%0d exp 0 1 00 0 0 0",
                  count0, empty0, data_out0, ovf0, udf0, count1);
      end
      tick(1'b1, 1'b0, 1'b0, 8'h5A);
      n_tests++;
      if ({data_out1, count0} !== {8'h5A, 3'd1}) begin
         n_fail++;
         $display("FAIL post_reset_fwft got d1=%h cnt=%0d exp 5a 1", data_out1, count0);
      end
      tick(1'b0, 1'b1, 1'b0, 8'h00);
      n_tests++;
      if ({data_out0, empty0} !== {8'h5A, 1'b1}) begin
         n_fail++;
         $display("FAIL post_reset_read got d=%h e=%b exp 5a 1", data_out0, empty0);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] exp_fwft;
      for (int i = 0; i < 300; i++) begin
         tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 15) == 0), 8'($urandom));
         exp_fwft = (q.size() != 0) ? q[0] : 8'h00;
         n_tests++;
         if ({count0, full0, empty0, afull0, aempty0, ovf0, udf0, data_out0, data_out1} !==
             {3'(q.size()), (q.size() == D), (q.size() == 0), (q.size() >= D - 1),
              (q.size() <= 1), m_ovf, m_udf, m_dout, exp_fwft}) begin
            n_fail++;
            $display("FAIL random[%0d] got cnt=%0d f=%b e=%b af=%b ae=%b ovf=%b udf=%b d0=%h d1=%h exp cnt=%0d ovf=%b udf=%b d0=%h d1=%h",
                     i, count0, full0, empty0, afull0, aempty0, ovf0, udf0, data_out0, data_out1,
                     q.size(), m_ovf, m_udf, m_dout, exp_fwft);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_wrap();
      test_simultaneous();
      test_underflow();
      test_fwft();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
Parametrised next-generation synchronous FIFO for single-clock datapath buffering.
- Depth need not be a power of two.
- Selectable standard (registered) or first-word-fall-through (FWFT) read mode.
- Adds occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags.
- Sits between a producer and a consumer in the same clock domain. Drop-in upgrade for the existing FIFO.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 8, number of entries (>=2, any integer).
- FWFT, 0, read mode: 0 = data_out registered on accepted read; 1 = head word presented combinationally.
- AFULL_LVL, DEPTH-1, almost_full asserts when count >= AFULL_LVL (1..DEPTH).
- AEMPTY_LVL, 1, almost_empty asserts when count <= AEMPTY_LVL (0..DEPTH-1).
- CNT_W (localparam), $clog2(DEPTH+1), width of count.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- w_en  in  1  write request.
- r_en  in  1  read request.
- clr_err  in  1  one-cycle pulse that clears the sticky error flags.
- data_in  in  WIDTH  write data.
- data_out  out  WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_LVL.
- almost_empty  out  1  count <= AEMPTY_LVL.
- count  out  CNT_W  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected while full.
- underflow  out  1  sticky: a read was rejected while empty.

Behaviour:
- Reset (rst sampled high at an edge):
  - wr_ptr, rd_ptr and count go to 0; data_out, overflow and underflow go to 0.
  - Memory contents are not reset.
  - After the reset edge: empty=1, almost_empty=1, full=0, almost_full=0 (AFULL_LVL>=1).
  - w_en, r_en and clr_err are ignored while rst is high.
  - Reset mid-operation discards all stored words; no partial state survives.
- Write accept: wa = w_en & !full. On wa: mem[wr_ptr] <= data_in and wr_ptr advances.
- Read accept: ra = r_en & !empty. On ra: rd_ptr advances.
- Pointer wrap: each pointer goes DEPTH-1 -> 0 by explicit compare. No reliance on power-of-two rollover.
- count update per edge:
  - +1 on wa only.
  - -1 on ra only.
  - Unchanged when both or neither.
- Simultaneous wa and ra are legal at any occupancy 1..DEPTH-1. Count holds; both pointers advance.
- When full: a write is rejected even if a read is accepted in the same cycle (no pass-through). Read proceeds; count becomes DEPTH-1; overflow sets.
- When empty: a read is rejected even if a write is accepted in the same cycle (no bypass). Write proceeds; count becomes 1; underflow sets.
- Flags (full, empty, almost_full, almost_empty) are decoded from the registered count, so each is valid the cycle after the causing edge.
- FWFT=0:
  - On ra, data_out <= mem[rd_ptr]; data is valid immediately after the read edge (1-cycle latency).
  - data_out holds its value when there is no ra.
- FWFT=1:
  - data_out = empty ? 0 : mem[rd_ptr], combinationally.
  - A word written into an empty FIFO appears on data_out the cycle after the write edge.
  - ra pops the displayed word.
- Error flags:
  - overflow sets on w_en & full; underflow sets on r_en & empty.
  - Both clear on clr_err.
  - If clr_err and a new error event occur in the same cycle, the set wins.
- Memory: simple dual-port, one write and one read per cycle. Reading and writing the same address in one cycle only happens at occupancy 0 or DEPTH, which the accept rules exclude.

Decomposition:
- Package sync_fifo_pkg: ptr_next() wrap function and default parameter constants.
- Sub-module sync_fifo_mem: WIDTH x DEPTH storage, registered write, asynchronous read, no reset. sync_fifo_flex drives its pointers.
- Control logic (pointers, count, flags, errors, read-mode mux) stays in sync_fifo_flex.

Test Plan:
- DEPTH=6, FWFT=0: write 6 words 0x11..0x16 -> full=1, count=6, almost_full=1 from 5. A 7th write leaves mem unchanged and sets overflow=1. Reading 6 words returns 0x11..0x16 in order; then empty=1.
- DEPTH=6 wrap: push and pop alternately 20 times with random data -> scoreboard matches every word, count oscillates 0/1, no error flags.
- Simultaneous: hold count=3, assert w_en and r_en for 4 cycles -> count stays 3, output order preserved. At full, a w_en+r_en pair -> count=5, overflow=1.
- Empty with r_en+w_en (0xA5) -> underflow=1, count=1. Next cycle, read returns 0xA5. A clr_err pulse -> underflow=0. clr_err coinciding with a new rejected read -> underflow stays 1.
- FWFT=1: write 0x3C into an empty FIFO -> data_out=0x3C and empty=0 one cycle after the write edge, without r_en. r_en -> data_out=0 and empty=1 next cycle.
- Assert rst at count=4 with w_en=1 -> next cycle count=0, empty=1, data_out=0, errors=0. A subsequent read of a new write returns only the new data.
